// File: rtl/audio_serial_pkg.sv
// Shared definitions for the serial audio link: default widths, the stereo frame type
// and the LRCK polarity used by both the transmit and the receive side.
package audio_serial_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_SLOT_WIDTH = 16;
    localparam int DEF_BCK_DIV    = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam logic LRCK_LEFT_LJ   = 1'b1;
    localparam logic LRCK_RIGHT_LJ  = 1'b0;
    localparam logic LRCK_LEFT_I2S  = 1'b0;
    localparam logic LRCK_RIGHT_I2S = 1'b1;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] left;
        logic [DEF_DATA_WIDTH-1:0] right;
    } frame_t;

    // Counter width that never collapses to zero bits for a range of one.
    function automatic int clog2Min1(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/audio_frame_fifo.sv
// Synchronous FIFO with occupancy output, used to buffer stereo frames ahead of the shifter.
// DEPTH must be a power of two so the pointers wrap by simple overflow.
module audio_frame_fifo
    import audio_serial_pkg::*;
#(
    parameter int WIDTH = 2 * DEF_DATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                     iCLK,
    input  logic                     AUD_DACLRCK,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int PTR_W = clog2Min1(DEPTH);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [LVL_W-1:0] r_level;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_level != LVL_W'(DEPTH));
    assign w_pop   = i_pop && (r_level != '0);
    assign o_data  = r_mem[r_rdPtr];
    assign o_level = r_level;

    always_ff @(posedge iCLK or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge iCLK) begin
        if (w_push) r_mem[r_wrPtr] <= i_data;
    end

endmodule

// File: rtl/audio_adc_serializer.sv
// ADC-side serial audio transmitter: FIFO-buffered stereo frames shifted out MSB-first.
// Define AUDIO_ADC_SERIALIZER_I2S_EN for I2S framing; default build is left-justified.
module audio_adc_serializer
    import audio_serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int SLOT_WIDTH = DEF_SLOT_WIDTH,
    parameter int BCK_DIV    = DEF_BCK_DIV,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                        iCLK,
    input  logic                        AUD_DACLRCK,
    input  logic [DATA_WIDTH-1:0]       iSampleL,
    input  logic [DATA_WIDTH-1:0]       iSampleR,
    input  logic                        iValid,
    output logic                        oReady,
    input  logic                        iClrUnderrun,
    output logic                        oAUD_BCK,
    output logic                        oAUD_LRCK,
    output logic                        oAUD_DAT,
    output logic                        oFrameStrobe,
    output logic                        oUnderrun,
    output logic [$clog2(FIFO_DEPTH):0] oLevel
);

    localparam int DIV_W  = clog2Min1(BCK_DIV);
    localparam int BIT_W  = clog2Min1(2 * SLOT_WIDTH);
    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int WORD_W = 2 * SLOT_WIDTH;

`ifdef AUDIO_ADC_SERIALIZER_I2S_EN
    localparam logic LRCK_LEFT  = LRCK_LEFT_I2S;
    localparam logic LRCK_RIGHT = LRCK_RIGHT_I2S;
`else
    localparam logic LRCK_LEFT  = LRCK_LEFT_LJ;
    localparam logic LRCK_RIGHT = LRCK_RIGHT_LJ;
`endif

    logic [DIV_W-1:0]        r_div;
    logic                    r_bck;
    logic [BIT_W-1:0]        r_bit;
    logic                    r_lrck;
    logic                    r_dat;
    logic [WORD_W-1:0]       r_shift;
    logic                    r_strobe;
    logic                    r_underrun;
`ifdef AUDIO_ADC_SERIALIZER_I2S_EN
    logic                    r_carry;
`endif

    logic                    w_wrap;
    logic                    w_fall;
    logic                    w_load;
    logic                    w_empty;
    logic                    w_push;
    logic                    w_pop;
    logic [2*DATA_WIDTH-1:0] w_head;
    logic [WORD_W-1:0]       w_word;

    assign w_wrap  = (r_div == DIV_W'(BCK_DIV - 1));
    assign w_fall  = w_wrap && r_bck;
    assign w_load  = w_fall && (r_bit == '0);
    assign w_empty = (oLevel == '0);
    assign oReady  = (oLevel != LVL_W'(FIFO_DEPTH));
    assign w_push  = iValid && oReady;
    assign w_pop   = w_load && !w_empty;

    audio_frame_fifo #(
        .WIDTH (2 * DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK        (iCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .i_push      (w_push),
        .i_data      ({iSampleL, iSampleR}),
        .i_pop       (w_pop),
        .o_data      (w_head),
        .o_level     (oLevel)
    );

    // Whole frame laid out as it leaves the wire: each sample at the top of its slot,
    // zero padding below; an empty FIFO yields an all-zero frame.
    always_comb begin
        w_word = '0;
        if (!w_empty) begin
            w_word[WORD_W-1 -: DATA_WIDTH]     = w_head[2*DATA_WIDTH-1 -: DATA_WIDTH];
            w_word[SLOT_WIDTH-1 -: DATA_WIDTH] = w_head[DATA_WIDTH-1:0];
        end
    end

    // Divider, bit counter and shifter; everything serial changes on the BCK falling edge.
    // In I2S mode the last bit of the frame spills into bit 0 of the next one via r_carry.
    always_ff @(posedge iCLK or negedge AUD_DACLRCK) begin
        if (!AUD_DACLRCK) begin
            r_div      <= '0;
            r_bck      <= 1'b0;
            r_bit      <= '0;
            r_lrck     <= 1'b0;
            r_dat      <= 1'b0;
            r_shift    <= '0;
            r_strobe   <= 1'b0;
            r_underrun <= 1'b0;
`ifdef AUDIO_ADC_SERIALIZER_I2S_EN
            r_carry    <= 1'b0;
`endif
        end else begin
            r_strobe <= 1'b0;
            r_div    <= w_wrap ? '0 : r_div + DIV_W'(1);
            if (w_wrap) r_bck <= ~r_bck;

            if (w_fall) begin
                r_bit <= (r_bit == BIT_W'(WORD_W - 1)) ? '0 : r_bit + BIT_W'(1);
                if (r_bit == '0) begin
                    r_lrck   <= LRCK_LEFT;
                    r_strobe <= 1'b1;
`ifdef AUDIO_ADC_SERIALIZER_I2S_EN
                    r_dat    <= r_carry;
                    r_shift  <= w_word;
                    r_carry  <= w_word[0];
`else
                    r_dat    <= w_word[WORD_W-1];
                    r_shift  <= w_word << 1;
`endif
                end else begin
                    if (r_bit == BIT_W'(SLOT_WIDTH)) r_lrck <= LRCK_RIGHT;
                    r_dat   <= r_shift[WORD_W-1];
                    r_shift <= r_shift << 1;
                end
            end

            if (w_load && w_empty)
                r_underrun <= 1'b1;
            else if (iClrUnderrun)
                r_underrun <= 1'b0;
        end
    end

    assign oAUD_BCK     = r_bck;
    assign oAUD_LRCK    = r_lrck;
    assign oAUD_DAT     = r_dat;
    assign oFrameStrobe = r_strobe;
    assign oUnderrun    = r_underrun;

endmodule

// File: tb/tb_audio_adc_serializer.sv
// Self-checking bench for audio_adc_serializer (BCK_DIV=2); honours AUDIO_ADC_SERIALIZER_I2S_EN.
// A FIFO model and a receiver-side deserializer feed a scoreboard of expected serial frames.
module tb_audio_adc_serializer;
    import audio_serial_pkg::*;

    localparam int DW        = 16;
    localparam int SW        = 16;
    localparam int BD        = 2;
    localparam int FD        = 4;
    localparam int FRAME_CYC = 2 * BD * 2 * SW;

`ifdef AUDIO_ADC_SERIALIZER_I2S_EN
    localparam logic [31:0] LR_EXP = 32'h0000FFFF;
`else
    localparam logic [31:0] LR_EXP = 32'hFFFF0000;
`endif

    logic          iCLK = 1'b0;
    logic          AUD_DACLRCK = 1'b0;
    logic [DW-1:0] iSampleL = '0;
    logic [DW-1:0] iSampleR = '0;
    logic          iValid = 1'b0;
    logic          iClrUnderrun = 1'b0;
    logic          oReady;
    logic          oAUD_BCK;
    logic          oAUD_LRCK;
    logic          oAUD_DAT;
    logic          oFrameStrobe;
    logic          oUnderrun;
    logic [2:0]    oLevel;

    audio_adc_serializer #(
        .DATA_WIDTH (DW),
        .SLOT_WIDTH (SW),
        .BCK_DIV    (BD),
        .FIFO_DEPTH (FD)
    ) dut (
        .iCLK         (iCLK),
        .AUD_DACLRCK  (AUD_DACLRCK),
        .iSampleL     (iSampleL),
        .iSampleR     (iSampleR),
        .iValid       (iValid),
        .oReady       (oReady),
        .iClrUnderrun (iClrUnderrun),
        .oAUD_BCK     (oAUD_BCK),
        .oAUD_LRCK    (oAUD_LRCK),
        .oAUD_DAT     (oAUD_DAT),
        .oFrameStrobe (oFrameStrobe),
        .oUnderrun    (oUnderrun),
        .oLevel       (oLevel)
    );

    always #5 iCLK = ~iCLK;

    int nVec  = 0;
    int nMiss = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMiss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model state
    logic [31:0] curExp = '0;
    logic [31:0] fifoQ[$];
    logic [31:0] serQ[$];
    bit          undM = 1'b0;
    bit          active = 1'b0;
    bit          prevBck = 1'b0;
    bit          carry = 1'b0;
    bit          lastAccept = 1'b0;
    int          bitCnt = 0;
    int          cyc = 0;
    int          nextStrobe = 2 * BD;
    logic [31:0] datAcc = '0;
    logic [31:0] lrAcc = '0;

    // Inputs are captured at the edge; the model advances and outputs are checked 1 time unit later.
    always @(posedge iCLK) begin : model
        logic        vIn;
        logic        clrIn;
        logic        rstEdge;
        logic [31:0] expIn;
        logic [31:0] fr;
        logic [31:0] e;
        int          lvlBefore;
        vIn     = iValid;
        clrIn   = iClrUnderrun;
        rstEdge = !AUD_DACLRCK;
        expIn   = curExp;
        #1;
        lastAccept = 1'b0;
        if (rstEdge || !AUD_DACLRCK) begin
            fifoQ.delete();
            serQ.delete();
            undM       = 1'b0;
            active     = 1'b0;
            prevBck    = 1'b0;
            carry      = 1'b0;
            cyc        = 0;
            nextStrobe = 2 * BD;
        end else begin
            cyc++;
            lvlBefore = fifoQ.size();
            if (oFrameStrobe || cyc == nextStrobe) begin
                checkOutput("strobe_cycle", oFrameStrobe ? 32'(cyc) : 32'hFFFFFFFF, 32'(nextStrobe));
                if (oFrameStrobe) begin
                    nextStrobe = cyc + FRAME_CYC;
                    fr = (lvlBefore > 0) ? fifoQ.pop_front() : 32'h0;
`ifdef AUDIO_ADC_SERIALIZER_I2S_EN
                    e     = {carry, fr[31:1]};
                    carry = fr[0];
`else
                    e = fr;
`endif
                    serQ.push_back(e);
                    active = 1'b1;
                    bitCnt = 0;
                end
            end
            if (vIn && lvlBefore != FD) begin
                fifoQ.push_back(expIn);
                lastAccept = 1'b1;
            end
            if (oFrameStrobe && lvlBefore == 0) undM = 1'b1;
            else if (clrIn) undM = 1'b0;
            checkOutput("level", 32'(oLevel), 32'(fifoQ.size()));
            checkOutput("ready", 32'(oReady), 32'(fifoQ.size() != FD));
            checkOutput("underrun", 32'(oUnderrun), 32'(undM));
            if (oAUD_BCK && !prevBck && active) begin
                datAcc = {datAcc[30:0], oAUD_DAT};
                lrAcc  = {lrAcc[30:0], oAUD_LRCK};
                bitCnt++;
                if (bitCnt == 32) begin
                    e = serQ.pop_front();
                    checkOutput("frame_data", datAcc, e);
                    checkOutput("frame_lrck", lrAcc, LR_EXP);
                    active = 1'b0;
                end
            end
            prevBck = oAUD_BCK;
        end
    end

    // Offer one frame and hold it until the model sees it accepted; iValid stays high on return.
    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic [31:0] exp);
        bit done;
        iSampleL = l;
        iSampleR = r;
        curExp   = exp;
        iValid   = 1'b1;
        done     = 1'b0;
        for (int n = 0; n < 400 && !done; n++) begin
            @(negedge iCLK);
            if (lastAccept) done = 1'b1;
        end
        if (!done) checkOutput("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic doReset();
        @(negedge iCLK);
        AUD_DACLRCK  = 1'b0;
        iValid       = 1'b0;
        iClrUnderrun = 1'b0;
        repeat (3) @(negedge iCLK);
        AUD_DACLRCK = 1'b1;
    endtask

    task automatic waitStrobe(input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge iCLK);
            if (oFrameStrobe) seen = 1'b1;
        end
        if (!seen) checkOutput("strobe_timeout", 32'd0, 32'd1);
    endtask

    task automatic waitCycle(input int target);
        bit hit;
        hit = 1'b0;
        for (int n = 0; n < 1000 && !hit; n++) begin
            @(negedge iCLK);
            if (cyc == target) hit = 1'b1;
        end
        if (!hit) checkOutput("cycle_timeout", 32'(cyc), 32'(target));
    endtask

    task automatic waitDrain();
        bit empty;
        empty = 1'b0;
        for (int n = 0; n < 2000 && !empty; n++) begin
            @(negedge iCLK);
            if (fifoQ.size() == 0 && serQ.size() == 0 && !active) empty = 1'b1;
        end
        if (!empty) checkOutput("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic checkAllReset(input string tag);
        checkOutput({tag, "_bck"}, 32'(oAUD_BCK), 32'd0);
        checkOutput({tag, "_lrck"}, 32'(oAUD_LRCK), 32'd0);
        checkOutput({tag, "_dat"}, 32'(oAUD_DAT), 32'd0);
        checkOutput({tag, "_strobe"}, 32'(oFrameStrobe), 32'd0);
        checkOutput({tag, "_underrun"}, 32'(oUnderrun), 32'd0);
        checkOutput({tag, "_level"}, 32'(oLevel), 32'd0);
        checkOutput({tag, "_ready"}, 32'(oReady), 32'd1);
    endtask

    typedef struct {
        frame_t      f;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[5];

    initial begin : stimulus
        int c0;
        tbl[0] = '{f: '{left: 16'hA55A, right: 16'h0F0F}, exp: 32'hA55A0F0F};
        tbl[1] = '{f: '{left: 16'h8001, right: 16'h7FFE}, exp: 32'h80017FFE};
        tbl[2] = '{f: '{left: 16'hFFFF, right: 16'h0000}, exp: 32'hFFFF0000};
        tbl[3] = '{f: '{left: 16'h0000, right: 16'hFFFF}, exp: 32'h0000FFFF};
        tbl[4] = '{f: '{left: 16'h1234, right: 16'hABCD}, exp: 32'h1234ABCD};

        #1;
        checkAllReset("por");
        repeat (2) @(negedge iCLK);
        AUD_DACLRCK = 1'b1;

        for (int i = 0; i < 5; i++)
            applyStimulus(tbl[i].f.left, tbl[i].f.right, tbl[i].exp);
        iValid = 1'b0;
        waitDrain();

        // Underrun on an empty first frame, clear, then push+pop in one cycle at level 2.
        doReset();
        waitStrobe(20);
        checkOutput("underrun_first_frame", 32'(oUnderrun), 32'd1);
        iClrUnderrun = 1'b1;
        @(negedge iCLK);
        iClrUnderrun = 1'b0;
        checkOutput("underrun_cleared", 32'(oUnderrun), 32'd0);
        applyStimulus(16'h1111, 16'h2222, 32'h11112222);
        applyStimulus(16'h3333, 16'h4444, 32'h33334444);
        iValid = 1'b0;
        waitCycle(FRAME_CYC + 2 * BD - 1);
        checkOutput("level_before_pushpop", 32'(oLevel), 32'd2);
        iSampleL = 16'h5555;
        iSampleR = 16'h6666;
        curExp   = 32'h55556666;
        iValid   = 1'b1;
        @(negedge iCLK);
        iValid = 1'b0;
        checkOutput("pushpop_strobe", 32'(oFrameStrobe), 32'd1);
        checkOutput("pushpop_level", 32'(oLevel), 32'd2);
        waitDrain();
        waitStrobe(FRAME_CYC + 4);
        checkOutput("underrun_again", 32'(oUnderrun), 32'd1);

        // Fill to full; a push is refused on the popping edge and accepted one cycle later.
        doReset();
        waitStrobe(20);
        for (int j = 0; j < 4; j++)
            applyStimulus(16'(16'hC000 + j), 16'(16'h0C00 + j),
                          {16'(16'hC000 + j), 16'(16'h0C00 + j)});
        iSampleL = 16'hC004;
        iSampleR = 16'h0C04;
        curExp   = 32'hC0040C04;
        repeat (3) @(negedge iCLK);
        checkOutput("full_level", 32'(oLevel), 32'd4);
        checkOutput("full_ready", 32'(oReady), 32'd0);
        waitStrobe(FRAME_CYC + 4);
        checkOutput("after_pop_level", 32'(oLevel), 32'd3);
        checkOutput("after_pop_ready", 32'(oReady), 32'd1);
        @(negedge iCLK);
        iValid = 1'b0;
        checkOutput("fifth_accepted_level", 32'(oLevel), 32'd4);
        waitDrain();

        // Asynchronous reset in the right slot around bit 20 with frames still queued.
        waitStrobe(FRAME_CYC + 4);
        c0 = cyc;
        applyStimulus(16'h9999, 16'h8888, 32'h99998888);
        applyStimulus(16'h7777, 16'h6666, 32'h77776666);
        iValid = 1'b0;
        waitCycle(c0 + 20 * 2 * BD + 2);
        checkOutput("pre_reset_lrck_right", 32'(oAUD_LRCK), 32'(LR_EXP[11]));
        #3;
        AUD_DACLRCK = 1'b0;
        #1;
        checkAllReset("midframe");
        repeat (2) @(negedge iCLK);
        AUD_DACLRCK = 1'b1;
        waitStrobe(20);
        checkOutput("restart_cycle", 32'(cyc), 32'(2 * BD));
        checkOutput("restart_underrun", 32'(oUnderrun), 32'd1);
        repeat (FRAME_CYC + 8) @(negedge iCLK);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not reach the end");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/audio_adc_serializer.md
Name: audio_adc_serializer

Overview:
- Transmit end of the CODEC serial audio link: the block that produces the ADC-side serial stream (bit clock, LR clock, serial data) that the audio interface's deserializer captures into its L/R input registers.
- Used as the CODEC stand-in for simulation and board loopback, and as a generic stereo serial transmitter.
- Takes stereo frames through a valid/ready handshake into a small FIFO and shifts them out MSB-first, left-justified.

Parameters:
- DATA_WIDTH, 16, sample width per channel.
- SLOT_WIDTH, 16, BCK periods per channel slot; must be >= DATA_WIDTH.
- BCK_DIV, 4, iCLK cycles per BCK half-period; must be >= 1.
- FIFO_DEPTH, 4, stereo frames buffered; power of two, >= 2.

Ports:
- iCLK  input  1  system clock; all logic is on its rising edge.
- AUD_DACLRCK  input  1  reset: asynchronous, active-low.
- iSampleL  input  DATA_WIDTH  left sample to queue.
- iSampleR  input  DATA_WIDTH  right sample to queue.
- iValid  input  1  frame offered.
- oReady  output  1  FIFO not full.
- iClrUnderrun  input  1  clears oUnderrun.
- oAUD_BCK  output  1  serial bit clock.
- oAUD_LRCK  output  1  frame clock: 1 = left slot, 0 = right slot.
- oAUD_DAT  output  1  serial data.
- oFrameStrobe  output  1  one-cycle pulse at each frame load.
- oUnderrun  output  1  sticky flag: a frame was needed while the FIFO was empty.
- oLevel  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset values: oAUD_BCK=0, oAUD_LRCK=0, oAUD_DAT=0, oFrameStrobe=0, oUnderrun=0, oLevel=0. oReady=1.
- Reset mid-frame: reset asserted mid-frame returns all state to these values immediately and discards the FIFO contents.
- Clock divider: counter div runs 0..BCK_DIV-1. On wrap, oAUD_BCK toggles, so one BCK period is 2*BCK_DIV iCLK cycles.
- Edge usage: data and LRCK change only on the BCK 1->0 edge. The receiver samples on 0->1.
- Bit counter: bit runs 0..2*SLOT_WIDTH-1 and advances on each BCK falling edge.
- Frame start: the first falling edge after reset (2*BCK_DIV cycles after release) is bit 0.
- At bit==0:
  - oAUD_LRCK<=1.
  - If oLevel!=0: pop the head frame into shift registers.
  - Else: load zeros and set oUnderrun.
  - oFrameStrobe pulses in that same cycle.
- At bit==SLOT_WIDTH: oAUD_LRCK<=0.
- Slot data, left-justified: slot bit k (k=0 at the LRCK edge) drives sample[DATA_WIDTH-1-k] for k<DATA_WIDTH, and 0 for the remainder of the slot.
- Push: occurs when iValid && oReady. oReady = (oLevel != FIFO_DEPTH), derived from registered state.
- Push and pop in the same cycle: both occur and oLevel is unchanged. When full, a push is refused even if a pop happens in that cycle.
- FIFO pointers wrap modulo FIFO_DEPTH.
- oUnderrun set/clear: stays set until iClrUnderrun. If set and clear coincide, set wins.
- Latency: a frame pushed into an empty FIFO is emitted at the next bit==0 edge. Its left MSB is valid on oAUD_DAT from that falling edge.

Optional Feature:
- Macro: AUDIO_ADC_SERIALIZER_I2S_EN.
- Defined: I2S framing.
  - oAUD_LRCK is 0 for the left slot and 1 for the right slot.
  - The MSB appears one BCK period after the LRCK edge. Slot bit k drives sample[DATA_WIDTH-k] for 1<=k<=DATA_WIDTH, and 0 otherwise.
  - The frame load and oFrameStrobe stay at bit==0.
- Undefined: left-justified as above.

Decomposition:
- Package audio_serial_pkg:
  - frame typedef {left, right} of DATA_WIDTH each.
  - Default constants for DATA_WIDTH, SLOT_WIDTH and BCK_DIV.
  - LRCK polarity constants, shared with the receive side.
- One natural sub-module: audio_frame_fifo, a synchronous FIFO with level output, instantiated for frame storage. Divider, bit counter and shifter stay in the top module.

Test Plan:
- BCK_DIV=2, push L=16'hA55A, R=16'h0F0F after reset -> BCK period 4 cycles; left slot bits read 1010010101011010 with LRCK=1; right slot reads 0000111100001111 with LRCK=0; oFrameStrobe pulses once.
- No push after reset -> first frame is all zeros, oUnderrun=1 and held; iClrUnderrun pulse -> 0; next empty frame -> 1 again.
- Push 5 frames back-to-back with iValid=1 -> 4 accepted, oReady=0, oLevel=4; after the next bit==0 pop -> oLevel=3, oReady=1; 5th frame accepted the following cycle.
- Push and pop in the same cycle with oLevel=2 -> oLevel stays 2; frames emerge in push order 1,2,3.
- Assert AUD_DACLRCK=0 during the right slot, bit 20 -> all outputs 0 asynchronously, oLevel=0; release -> first falling BCK after 2*BCK_DIV cycles starts bit 0.
- With AUDIO_ADC_SERIALIZER_I2S_EN, push L=16'h8001 -> LRCK=0, first slot bit 0, then 1, then 0x0001 pattern; LSB 1 lands on slot bit 16.
